// File: rtl/fp16_alu_pkg.sv
// Shared definitions for the fp16 ALU significand datapath.
package fp16_alu_pkg;

    // Significand width including the hidden bit.
    localparam int MANT_W = 11;

    // Sequencer states of the multi-cycle adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Integer ceiling division, used to size chunk counters.
    function automatic int ceil_div(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

endpackage

// File: rtl/serial_ripple_add_if.sv
// Start/done handshake and operand/result bus of the serial ripple adder.
interface serial_ripple_add_if
    import fp16_alu_pkg::*;
#(
    parameter int WIDTH = MANT_W
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Adder side: consumes operands, produces status and result.
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/full_add.sv
// One-bit full adder cell, the additive twin of the full subtractor cell.
module full_add (
    output logic o_sum,
    output logic o_cout,
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_ripple_add.sv
// Multi-cycle ripple-carry adder: STEP bits per clock through one carry register.
module serial_ripple_add
    import fp16_alu_pkg::*;
#(
    parameter int WIDTH = MANT_W,
    parameter int STEP  = 1
) (
    input logic               clk,
    input logic               rst,
    serial_ripple_add_if.slave bus
);

    // Number of chunks and the zero-padded working width they cover.
    localparam int N     = ceil_div(WIDTH, STEP);
    localparam int PAD_W = N * STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    // Position of operand bit WIDTH-1 inside the last chunk; its carry is cout.
    localparam int LAST_J = (WIDTH - 1) - (N - 1) * STEP;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_idx;
    logic [PAD_W-1:0] r_a;
    logic [PAD_W-1:0] r_b;
    logic [PAD_W-1:0] r_acc;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [STEP-1:0]  w_s;
    logic [STEP:0]    w_c;
    logic [PAD_W-1:0] w_acc_next;

    // Operands shift right each step, so the active chunk is always the low STEP bits.
    assign w_c[0] = r_carry;

    genvar j;
    generate
        for (j = 0; j < STEP; j++) begin : g_chunk
            full_add u_fa (
                .o_sum  (w_s[j]),
                .o_cout (w_c[j+1]),
                .i_a    (r_a[j]),
                .i_b    (r_b[j]),
                .i_cin  (w_c[j])
            );
        end
    endgenerate

    // Shadow accumulator fills from the top; after N steps chunk k sits at k*STEP.
    assign w_acc_next = (r_acc >> STEP) | (PAD_W'(w_s) << (PAD_W - STEP));

    // Sequencer with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_a     <= PAD_W'(bus.a);
                        r_b     <= PAD_W'(bus.b);
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> STEP;
                    r_b     <= r_b >> STEP;
                    r_acc   <= w_acc_next;
                    r_carry <= w_c[STEP];
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= w_acc_next[WIDTH-1:0];
                        r_cout  <= w_c[LAST_J+1];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_ripple_add.sv
// Scoreboard bench for serial_ripple_add with STEP=1 and STEP=4 instances.
module tb_serial_ripple_add;

    localparam int N1 = 11;
    localparam int N4 = 3;

    typedef struct {
        logic [11:0] res;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    logic rst_seen = 1'b0;
    int   stim_to = 0;
    logic finish_req = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    int   run1 = 0;
    int   run4 = 0;

    exp_t q1[$];
    exp_t q4[$];

    serial_ripple_add_if #(.WIDTH(11)) if1 ();
    serial_ripple_add_if #(.WIDTH(11)) if4 ();

    serial_ripple_add #(.WIDTH(11), .STEP(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    serial_ripple_add #(.WIDTH(11), .STEP(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            q1.delete();
            q4.delete();
            run1 = 0;
            run4 = 0;
            check("reset_state_step1", 32'({if1.busy, if1.done, if1.cout, if1.sum}), 32'd0);
            check("reset_state_step4", 32'({if4.busy, if4.done, if4.cout, if4.sum}), 32'd0);
        end else begin
            if (if1.busy === 1'b1) run1++;
            if (if4.busy === 1'b1) run4++;
            if (if1.done !== 1'b0) begin
                if (q1.size() == 0) begin
                    check("done_without_request_step1", 32'(q1.size()), 32'd1);
                end else begin
                    e = q1.pop_front();
                    check("result_step1", 32'({if1.cout, if1.sum}), 32'(e.res));
                    check("latency_step1", 32'(cyc), 32'(e.cyc));
                    check("busy_len_step1", 32'(run1), 32'(N1));
                end
                run1 = 0;
            end
            if (if4.done !== 1'b0) begin
                if (q4.size() == 0) begin
                    check("done_without_request_step4", 32'(q4.size()), 32'd1);
                end else begin
                    e = q4.pop_front();
                    check("result_step4", 32'({if4.cout, if4.sum}), 32'(e.res));
                    check("latency_step4", 32'(cyc), 32'(e.cyc));
                    check("busy_len_step4", 32'(run4), 32'(N4));
                end
                run4 = 0;
            end
        end
        if (finish_req) begin
            check("pending_step1", 32'(q1.size()), 32'd0);
            check("pending_step4", 32'(q4.size()), 32'd0);
            check("stimulus_timeouts", 32'(stim_to), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // Waits for the chosen adder to be free, issues one start, records the expectation.
    task automatic start_op(input int sel, input logic [10:0] a, input logic [10:0] b,
                            input logic c, input logic [11:0] exp_res);
        int   t;
        exp_t e;
        t = 0;
        while (((sel == 1) ? if1.busy : if4.busy) !== 1'b0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) stim_to++;
        if (sel == 1) begin
            if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = c;
        end else begin
            if4.start = 1'b1; if4.a = a; if4.b = b; if4.cin = c;
        end
        @(posedge clk);
        #1;
        e.res = exp_res;
        e.cyc = cyc + ((sel == 1) ? N1 : N4);
        if (sel == 1) begin
            q1.push_back(e);
            if1.start = 1'b0;
        end else begin
            q4.push_back(e);
            if4.start = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((if1.busy !== 1'b0 || if4.busy !== 1'b0) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) stim_to++;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [10:0] ra;
        logic [10:0] rb;
        logic        rc;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic carries and wrap-around.
        start_op(1, 11'h3FF, 11'h001, 1'b0, 12'h400);
        start_op(1, 11'h7FF, 11'h001, 1'b0, 12'h800);
        start_op(1, 11'h7FF, 11'h7FF, 1'b1, 12'hFFF);
        wait_idle();

        // Start held high during RUN must be ignored.
        start_op(1, 11'h001, 11'h002, 1'b0, 12'h003);
        if1.start = 1'b1; if1.a = 11'h123; if1.b = 11'h456; if1.cin = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        if1.start = 1'b0;
        wait_idle();

        // Back-to-back: second start lands in the DONE cycle of the first.
        start_op(1, 11'h200, 11'h0F0, 1'b0, 12'h2F0);
        start_op(1, 11'h555, 11'h2AA, 1'b1, 12'h800);
        wait_idle();

        // Reset in the middle of RUN abandons the operation.
        start_op(1, 11'h111, 11'h222, 1'b0, 12'h333);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start_op(1, 11'h0F0, 11'h00F, 1'b1, 12'h100);
        wait_idle();

        // STEP=4 instance: partial last chunk, directed then random.
        start_op(4, 11'h7FF, 11'h001, 1'b0, 12'h800);
        start_op(4, 11'h3FF, 11'h001, 1'b0, 12'h400);
        start_op(4, 11'h555, 11'h2AA, 1'b1, 12'h800);
        start_op(4, 11'h7FF, 11'h7FF, 1'b1, 12'hFFF);
        start_op(4, 11'h000, 11'h000, 1'b0, 12'h000);
        for (int i = 0; i < 1000; i++) begin
            ra = 11'($urandom);
            rb = 11'($urandom);
            rc = 1'($urandom);
            start_op(4, ra, rb, rc, 12'(ra) + 12'(rb) + 12'(rc));
        end
        wait_idle();

        finish_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL finish_timeout: got no summary expected summary");
        $fatal(1, "monitor did not finish");
    end

endmodule

// File: doc/serial_ripple_add.md
Name: serial_ripple_add

Overview:
- Multi-cycle ripple-carry adder for the 11-bit significand path of the 16-bit floating-point ALU.
- It is the additive counterpart to the combinational ripple subtractor.
- Operands are latched on a start handshake and summed STEP bits per clock through a single carry register.
- It reports sum and carry-out with a one-cycle done pulse, trading latency for area in the add/sub datapath.

Parameters:
- WIDTH, 11, operand/sum width in bits (significand incl. hidden bit).
- STEP, 1, bits summed per clock; 1 <= STEP <= WIDTH; last chunk may be partial.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  augend; sampled on the accepting edge.
- b  input  WIDTH  addend; sampled on the accepting edge.
- cin  input  1  carry-in to bit 0; sampled on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset:
  - Synchronous, active-high on clk; the only reset in the block.
  - busy=0, done=0, sum=0, cout=0.
  - State goes to IDLE, chunk index 0, carry register 0.
  - Reset mid-operation abandons the operation; no done is produced.
- Counts: N = ceil(WIDTH/STEP); WIDTH=11, STEP=1 gives N=11.
- States:
  - IDLE: busy=0, done=0. On start=1, latch a, b, cin into operand and carry registers, clear the chunk index, go to RUN.
  - RUN: busy=1. Each edge:
    - Add operand chunk [i*STEP +: STEP] plus the carry register.
    - Write that chunk of the sum register and update the carry register.
    - Increment i. Chunks above WIDTH-1 are masked off.
    - After chunk N-1, load cout from the final carry and go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 here is accepted exactly as in IDLE: new operands are latched and the next state is RUN (back-to-back).
    - Otherwise the next state is IDLE.
- Latency:
  - start sampled high at edge k gives busy high after edge k.
  - done is high in the cycle following edge k+N, i.e. N+1 cycles after start.
  - Throughput is one result per N+1 cycles.
- start while busy=1 is ignored; latched operands are unaffected.
- Output hold and sum bits:
  - sum/cout update only at completion and hold their value until the next completion or reset.
  - Partially written sum bits during RUN are not visible; RTL uses a shadow accumulator, and sum is loaded at completion.
- Arithmetic:
  - Unsigned. {cout, sum} = a + b + cin exactly, WIDTH+1 bits.
  - Wrap-around modulo 2^WIDTH; overflow is reported only via cout.
- Operand inputs changing after acceptance have no effect on the result.
- No X on outputs after reset, regardless of the inputs.

Decomposition:
- Shared package (fp16_alu_pkg):
  - Significand width constant MANT_W=11.
  - State enum: IDLE, RUN, DONE.
  - Helper function for ceil division used to size the chunk counter.
- Sub-module full_add (sum, carry-out, a, b, cin), the 1-bit full adder mirroring the team's full subtractor cell.
  - Instantiated STEP times in a generate loop to form the per-cycle chunk adder.

Test Plan:
- WIDTH=11, STEP=1: a=0x3FF, b=0x001, cin=0, start pulse → done 12 cycles after start, sum=0x400, cout=0, busy high for exactly 11 cycles.
- a=0x7FF, b=0x001, cin=0 → sum=0x000, cout=1; then a=0x7FF, b=0x7FF, cin=1 → sum=0x7FF, cout=1.
- start held high with a=0x123, b=0x456 during RUN of a prior operation (a=0x001, b=0x002) → prior result sum=0x003, cout=0 unchanged; second start not accepted until busy=0.
- start asserted in the DONE cycle with a=0x555, b=0x2AA, cin=1 → first result emitted, second result sum=0x000, cout=1, done N+1 cycles later.
- rst asserted at cycle 5 of RUN → next cycle busy=0, done=0, sum=0, cout=0; no done pulse; a subsequent start completes normally.
- STEP=4, WIDTH=11: random 1000 operand pairs → done 4 cycles after start; {cout, sum} equals a+b+cin.
